sha256_job_ctrl: RTL
====================

# sha256_job_ctrl

Host-side job controller for the simplified SHA-256 core. It accepts a 20-word message on a valid/ready input stream and writes it into the shared word memory. It then pulses the core's `start`, hands the memory port to the core until `done` rises, reads the 8-word digest back out of memory and streams it to the host. It is the initiator of the core's start/done handshake, the writer of the core's message and the reader of its digest.

## Interface
- `MSG_WORDS`, 20: message words per job; fixed by the core.
- `DIGEST_WORDS`, 8: digest words read back.
- `READ_LAT`, 2: cycles from controller registering `mem_addr` to capturing `mem_read_data`.
- `TIMEOUT_CYCLES`, 2048: watchdog limit; used only with `SHA_CTRL_TIMEOUT_EN`.

Ports:
- `clk` in 1: clock. `reset_n` in 1: reset, asynchronous, active-low.
- `message_addr`, `output_addr` in 16: memory base addresses; also wired to the core. Must be stable while `busy`.
- `in_valid` in 1, `in_ready` out 1, `in_data` in 32: message input stream.
- `out_valid` out 1, `out_ready` in 1, `out_data` out 32, `out_last` out 1: digest output stream.
- `busy` out 1: job in progress (any state other than IDLE).
- `error` out 1: one-cycle watchdog pulse.
- `core_start` out 1, `core_done` in 1: core handshake.
- `core_mem_we` in 1, `core_mem_addr` in 16, `core_mem_write_data` in 32: core memory request.
- `mem_we` out 1, `mem_addr` out 16, `mem_write_data` out 32, `mem_read_data` in 32: shared memory port.

## Operation
- States: IDLE, LOAD, START, WAIT, FETCH, DRAIN.
- IDLE/LOAD: `in_ready`=1 (combinational on state).
  - Each accepted word (`in_valid`&`in_ready`) registers `mem_we`=1, `mem_addr`=`message_addr`+cnt, `mem_write_data`=`in_data`. `cnt` increments.
  - IDLE moves to LOAD on the first accepted word.
  - The accept that makes `cnt`==`MSG_WORDS` moves to START.
  - Cycles with no accept register `mem_we`=0.
- START: one cycle.
  - `core_start`=1 registered and `mem_we`=0.
  - `done_q` is captured from `core_done`.
  - Next state is WAIT.
- WAIT: memory outputs are combinationally muxed to `core_mem_*`.
  - Leave on `core_done` & ~`done_q` (rising edge; `core_done` is sticky in the core). A `done` already high at START is ignored.
  - On leaving, clear `idx` and go to FETCH.
- FETCH: register `mem_we`=0 and `mem_addr`=`output_addr`+`idx`. Wait `READ_LAT` cycles, capture `mem_read_data` into `out_data`, set `out_valid`=1, then go to DRAIN.
- DRAIN: hold `out_data` and `out_valid` until `out_ready`. `out_last`=1 when `idx`==`DIGEST_WORDS`-1.
  - On handshake with `idx` < 7: increment `idx`, drop `out_valid`, go to FETCH.
  - On handshake with `idx`==7: drop `out_valid`, clear counters, go to IDLE.
- Mux rule: controller's registered memory outputs in every state except WAIT. `mem_we` is never driven from both sides.
- Counters are 5-bit `cnt` (0..20) and 3-bit `idx`. Address add is 16-bit and wraps modulo 2^16.

## Timing
- Reset values: `in_ready`=1 (IDLE), `out_valid`=0, `out_last`=0, `out_data`=0, `core_start`=0, `busy`=0, `error`=0, `mem_we`=0, `mem_addr`=0, `mem_write_data`=0, counters 0.
- Message write: the memory write for an accepted word is presented in the cycle after acceptance. Full throughput is 1 word/cycle, giving 20 write cycles.
- `core_start`: high exactly 1 cycle, in the cycle after the 20th write is presented.
- First `out_valid`: `READ_LAT`+1 cycles after the `core_done` rising edge.
- Each subsequent word: `READ_LAT`+1 cycles after the previous handshake. Digest readback is at most 8×(`READ_LAT`+1) cycles with `out_ready` held at 1.
- Backpressure: `out_data` and `out_last` must not change while `out_valid`&~`out_ready`.
- `in_valid` while not in IDLE/LOAD: not accepted (`in_ready`=0); no memory write.
- Reset mid-job, asynchronous in any state: all outputs return to reset values immediately. `core_start`=0 and a partial message is discarded. The core is reset by the same `reset_n`.

## Configuration
- `SHA_CTRL_TIMEOUT_EN` defined:
  - A 12-bit watchdog counts cycles in WAIT.
  - On reaching `TIMEOUT_CYCLES` without a `done` edge: `error`=1 for one cycle, go to IDLE, no digest output.
- `SHA_CTRL_TIMEOUT_EN` undefined: WAIT is unbounded, `error` is tied 0 and no counter is synthesized.

## Test plan
- Load words 0x00000000..0x00000013 with `in_valid` held at 1. Required:
  - 20 writes at `message_addr`=0x0000..0x0013 with matching data in consecutive cycles.
  - `core_start` 1-cycle pulse in the next cycle.
- Stub core raises `done` 100 cycles after start; memory preloaded with 0x11111111..0x88888888 at `output_addr`=0x0100. Required:
  - 8 output words in order.
  - `out_last` only on 0x88888888.
  - First `out_valid` 3 cycles after the `done` edge.
- Random `out_ready` (50%) during DRAIN. Required: each word held stable until handshake; no word lost or duplicated.
- `in_valid` gaps (1 idle cycle between words) and `in_valid` asserted during WAIT. Required: only 20 writes, no input accepted in WAIT.
- `reset_n` low for 1 cycle after word 10. Required: all outputs at reset values; a new 20-word job completes correctly.
- `SHA_CTRL_TIMEOUT_EN` with a stub that never signals `done`. Required: `error` pulses at cycle 2048 of WAIT, state returns to IDLE, `out_valid` never asserted.

Source files
------------

// File: rtl/sha256_job_ctrl.sv
// sha256_job_ctrl: loads a 20-word message into shared memory, runs the SHA-256 core, streams the digest back.
// Define SHA_CTRL_TIMEOUT_EN to add a watchdog on the wait-for-done phase (error pulse, job aborted).
module sha256_job_ctrl #(
  parameter int MSG_WORDS    = 20,
  parameter int DIGEST_WORDS = 8,
  parameter int READ_LAT     = 2
`ifdef SHA_CTRL_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 2048
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] message_addr,
  input  logic [15:0] output_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        error,
  output logic        core_start,
  input  logic        core_done,
  input  logic        core_mem_we,
  input  logic [15:0] core_mem_addr,
  input  logic [31:0] core_mem_write_data,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);
  localparam int               LAT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [4:0]       CNT_LAST = 5'(MSG_WORDS - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DIGEST_WORDS - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LAT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    FETCH = 3'd4,
    DRAIN = 3'd5
  } state_t;

  state_t           state_r;
  logic [4:0]       cnt_r;
  logic [2:0]       idx_r;
  logic [LAT_W-1:0] lat_r;
  logic             done_q_r;
  logic             ctl_we_r;
  logic [15:0]      ctl_addr_r;
  logic [31:0]      ctl_wdata_r;
  logic             out_valid_r;
  logic [31:0]      out_data_r;
  logic             core_start_r;
  logic             accept_s;
  logic             done_rise_s;

  assign in_ready    = (state_r == IDLE) || (state_r == LOAD);
  assign accept_s    = in_valid & in_ready;
  assign done_rise_s = core_done & ~done_q_r;
  assign busy        = (state_r != IDLE);
  assign out_valid   = out_valid_r;
  assign out_data    = out_data_r;
  assign out_last    = (state_r == DRAIN) && (idx_r == IDX_LAST);
  assign core_start  = core_start_r;

`ifdef SHA_CTRL_TIMEOUT_EN
  localparam logic [11:0] WDOG_LAST = 12'(TIMEOUT_CYCLES - 1);
  logic [11:0] wdog_r;
  logic        error_r;
  assign error = error_r;
`else
  assign error = 1'b0;
`endif

  // The core owns the memory port only while the controller waits for done.
  always_comb begin
    if (state_r == WAIT) begin
      mem_we         = core_mem_we;
      mem_addr       = core_mem_addr;
      mem_write_data = core_mem_write_data;
    end else begin
      mem_we         = ctl_we_r;
      mem_addr       = ctl_addr_r;
      mem_write_data = ctl_wdata_r;
    end
  end

  // Job sequencing: message load, start pulse, done wait, digest fetch/drain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      cnt_r        <= 5'd0;
      idx_r        <= 3'd0;
      lat_r        <= '0;
      done_q_r     <= 1'b0;
      ctl_we_r     <= 1'b0;
      ctl_addr_r   <= 16'd0;
      ctl_wdata_r  <= 32'd0;
      out_valid_r  <= 1'b0;
      out_data_r   <= 32'd0;
      core_start_r <= 1'b0;
`ifdef SHA_CTRL_TIMEOUT_EN
      wdog_r       <= 12'd0;
      error_r      <= 1'b0;
`endif
    end else begin
      core_start_r <= 1'b0;
`ifdef SHA_CTRL_TIMEOUT_EN
      error_r      <= 1'b0;
`endif
      case (state_r)
        IDLE, LOAD: begin
          if (accept_s) begin
            ctl_we_r    <= 1'b1;
            ctl_addr_r  <= message_addr + {11'd0, cnt_r};
            ctl_wdata_r <= in_data;
            cnt_r       <= cnt_r + 5'd1;
            state_r     <= (cnt_r == CNT_LAST) ? START : LOAD;
          end else begin
            ctl_we_r <= 1'b0;
          end
        end
        START: begin
          ctl_we_r     <= 1'b0;
          core_start_r <= 1'b1;
          done_q_r     <= core_done;
`ifdef SHA_CTRL_TIMEOUT_EN
          wdog_r       <= 12'd0;
`endif
          state_r      <= WAIT;
        end
        WAIT: begin
          // done is sticky in the core, so only a fresh rising edge ends the job.
          done_q_r <= core_done;
          if (done_rise_s) begin
            idx_r      <= 3'd0;
            lat_r      <= '0;
            ctl_addr_r <= output_addr;
            state_r    <= FETCH;
          end
`ifdef SHA_CTRL_TIMEOUT_EN
          else if (wdog_r == WDOG_LAST) begin
            error_r <= 1'b1;
            cnt_r   <= 5'd0;
            idx_r   <= 3'd0;
            state_r <= IDLE;
          end else begin
            wdog_r <= wdog_r + 12'd1;
          end
`endif
        end
        FETCH: begin
          ctl_we_r   <= 1'b0;
          ctl_addr_r <= output_addr + {13'd0, idx_r};
          if (lat_r == LAT_LAST) begin
            out_data_r  <= mem_read_data;
            out_valid_r <= 1'b1;
            state_r     <= DRAIN;
          end else begin
            lat_r <= lat_r + LAT_W'(1);
          end
        end
        DRAIN: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            if (idx_r == IDX_LAST) begin
              cnt_r   <= 5'd0;
              idx_r   <= 3'd0;
              state_r <= IDLE;
            end else begin
              idx_r      <= idx_r + 3'd1;
              ctl_addr_r <= output_addr + {13'd0, 3'(idx_r + 3'd1)};
              lat_r      <= '0;
              state_r    <= FETCH;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end
endmodule
